// File: rtl/fetch_queue_if.sv
// fetch_queue_if: SRAM read port, redirect and instruction handshake bundle for fetch_queue.
interface fetch_queue_if;
    logic         i_redirect;
    logic [7:0]   i_redirect_pc;
    logic         i_write_busy;
    logic         o_read_en;
    logic [31:0]  o_read_addr;
    logic [287:0] i_datas;
    logic         o_inst_valid;
    logic [71:0]  o_inst;
    logic [7:0]   o_inst_pc;
    logic         i_inst_ready;

    modport master (
        input  i_redirect, i_redirect_pc, i_write_busy, i_datas, i_inst_ready,
        output o_read_en, o_read_addr, o_inst_valid, o_inst, o_inst_pc
    );

    modport slave (
        output i_redirect, i_redirect_pc, i_write_busy, i_datas, i_inst_ready,
        input  o_read_en, o_read_addr, o_inst_valid, o_inst, o_inst_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: issues four-wide SRAM reads and buffers returned words in an in-order queue.
// Optional macro FETCH_QUEUE_PERF_CNT_EN adds the o_stall_cnt output.
module fetch_queue #(
    parameter int DEPTH = 8
) (
    input  logic          i_fire,
    input  logic          rst,
    fetch_queue_if.master bus
`ifdef FETCH_QUEUE_PERF_CNT_EN
    ,
    output logic [15:0]   o_stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 5);

    logic [7:0]    fetch_pc_q, fetch_pc_d;
    logic [7:0]    issue_pc_q, issue_pc_d;
    logic          inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [71:0]   inst_mem [DEPTH];
    logic [7:0]    pc_mem [DEPTH];
    logic          read_en, capture, pop;

    // Issue/capture/pop decisions and next-state; redirect overrides everything.
    always_comb begin
        read_en    = rst && !bus.i_redirect && !bus.i_write_busy &&
                     (count_q + (inflight_q ? CW'(4) : CW'(0))) <= CW'(DEPTH - 4);
        capture    = inflight_q && !bus.i_redirect;
        pop        = (count_q != CW'(0)) && bus.i_inst_ready && !bus.i_redirect;
        count_d    = bus.i_redirect ? CW'(0) :
                     count_q + (capture ? CW'(4) : CW'(0)) - (pop ? CW'(1) : CW'(0));
        head_d     = bus.i_redirect ? AW'(0) :
                     !pop ? head_q : (head_q == AW'(DEPTH - 1)) ? AW'(0) : head_q + AW'(1);
        tail_d     = bus.i_redirect ? AW'(0) :
                     !capture ? tail_q : (tail_q == AW'(DEPTH - 4)) ? AW'(0) : tail_q + AW'(4);
        inflight_d = read_en;
        fetch_pc_d = bus.i_redirect ? bus.i_redirect_pc : read_en ? fetch_pc_q + 8'd4 : fetch_pc_q;
        issue_pc_d = read_en ? fetch_pc_q : issue_pc_q;
    end

    // Control state; reset asynchronously drops queue contents and any in-flight read.
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= 8'd0;
            issue_pc_q <= 8'd0;
            inflight_q <= 1'b0;
            count_q    <= CW'(0);
            head_q     <= AW'(0);
            tail_q     <= AW'(0);
        end else begin
            fetch_pc_q <= fetch_pc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Queue storage; tail is always 4-aligned so the four lanes never straddle the wrap.
    always_ff @(posedge i_fire) begin
        if (capture) begin
            for (int k = 0; k < 4; k++) begin
                inst_mem[tail_q + AW'(k)] <= bus.i_datas[72*k +: 72];
                pc_mem[tail_q + AW'(k)]   <= issue_pc_q + 8'(k);
            end
        end
    end

    assign bus.o_read_en    = read_en;
    assign bus.o_read_addr  = {fetch_pc_q + 8'd3, fetch_pc_q + 8'd2, fetch_pc_q + 8'd1, fetch_pc_q};
    assign bus.o_inst_valid = count_q != CW'(0);
    assign bus.o_inst       = inst_mem[head_q];
    assign bus.o_inst_pc    = pc_mem[head_q];

`ifdef FETCH_QUEUE_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where no read could issue; a redirect clears it.
    always_comb begin
        stall_cnt_d = bus.i_redirect ? 16'd0 :
                      (!read_en && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // Stall counter register.
    always_ff @(posedge i_fire or negedge rst) begin
        if (!rst) stall_cnt_q <= 16'd0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and random stimulus checked against a queue-based reference model.
module tb_fetch_queue;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fetch_queue_if bus();

`ifdef FETCH_QUEUE_PERF_CNT_EN
    logic [15:0] stall_cnt;
    fetch_queue #(.DEPTH(DEPTH)) dut (.i_fire(clk), .rst(rst_n), .bus(bus), .o_stall_cnt(stall_cnt));
`else
    fetch_queue #(.DEPTH(DEPTH)) dut (.i_fire(clk), .rst(rst_n), .bus(bus));
`endif

    typedef struct {
        logic [7:0]  pc;
        logic [71:0] d;
    } ent_t;

    ent_t       q[$];
    logic [7:0] m_fpc;
    logic [7:0] m_ipc;
    bit         m_inf;
    int         m_stall;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_fpc   = 8'd0;
        m_ipc   = 8'd0;
        m_inf   = 1'b0;
        m_stall = 0;
    endtask

    function automatic bit exp_en();
        return !bus.i_redirect && !bus.i_write_busy && (q.size() + (m_inf ? 4 : 0)) <= DEPTH - 4;
    endfunction

    function automatic logic [31:0] exp_addr();
        logic [31:0] a;
        for (int k = 0; k < 4; k++) a[8*k +: 8] = m_fpc + 8'(k);
        return a;
    endfunction

    task automatic step(input string tag);
        bit           en;
        logic [287:0] d;
        for (int k = 0; k < 9; k++) d[32*k +: 32] = $urandom();
        bus.i_datas = d;
        #1;
        en = exp_en();
        chk({tag, ":read_en"}, 72'(bus.o_read_en), 72'(en));
        chk({tag, ":read_addr"}, 72'(bus.o_read_addr), 72'(exp_addr()));
        chk({tag, ":valid"}, 72'(bus.o_inst_valid), 72'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, ":inst"}, bus.o_inst, q[0].d);
            chk({tag, ":inst_pc"}, 72'(bus.o_inst_pc), 72'(q[0].pc));
        end
`ifdef FETCH_QUEUE_PERF_CNT_EN
        chk({tag, ":stall_cnt"}, 72'(stall_cnt), 72'(m_stall));
`endif
        @(posedge clk);
        if (bus.i_redirect) begin
            q.delete();
            m_inf   = 1'b0;
            m_fpc   = bus.i_redirect_pc;
            m_stall = 0;
        end else begin
            if (!en && m_stall < 65535) m_stall++;
            if (q.size() != 0 && bus.i_inst_ready) void'(q.pop_front());
            if (m_inf) for (int k = 0; k < 4; k++) q.push_back('{m_ipc + 8'(k), d[72*k +: 72]});
            m_inf = en;
            if (en) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + 8'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = 8'd0;
        bus.i_write_busy  = 1'b0;
        bus.i_inst_ready  = 1'b1;
        bus.i_datas       = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        chk("rst:valid", 72'(bus.o_inst_valid), 72'(0));
        chk("rst:read_en", 72'(bus.o_read_en), 72'(0));
        chk("rst:addr", 72'(bus.o_read_addr), 72'(32'h03020100));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) step("stream");

        bus.i_inst_ready = 1'b0;
        repeat (12) step("full");
        bus.i_inst_ready = 1'b1;
        repeat (10) step("drain");

        for (int i = 0; i < 20 && !m_inf; i++) step("sync");
        chk("sync:inflight", 72'(m_inf), 72'(1));
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 8'hFE;
        step("redir");
        bus.i_redirect = 1'b0;
        #1 chk("redir:addr", 72'(bus.o_read_addr), 72'(32'h0100FFFE));
        repeat (8) step("after_redir");

        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 8'h40;
        step("redir2");
        bus.i_redirect   = 1'b0;
        bus.i_write_busy = 1'b1;
        repeat (3) step("busy");
        bus.i_write_busy = 1'b0;
        repeat (8) step("busy_rel");

        repeat (400) begin
            bus.i_inst_ready  = $urandom_range(0, 9) < 7;
            bus.i_write_busy  = $urandom_range(0, 9) < 2;
            bus.i_redirect    = $urandom_range(0, 19) == 0;
            bus.i_redirect_pc = 8'($urandom());
            step("rand");
        end

        bus.i_inst_ready = 1'b1;
        bus.i_write_busy = 1'b0;
        bus.i_redirect   = 1'b0;
        repeat (4) step("pre_rst");
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst:valid", 72'(bus.o_inst_valid), 72'(0));
        chk("mid_rst:read_en", 72'(bus.o_read_en), 72'(0));
        chk("mid_rst:addr", 72'(bus.o_read_addr), 72'(32'h03020100));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step("restart");

`ifdef FETCH_QUEUE_PERF_CNT_EN
        bus.i_inst_ready = 1'b0;
        repeat (25) step("stall");
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 8'h10;
        step("stall_redir");
        bus.i_redirect = 1'b0;
        #1 chk("stall:cleared", 72'(stall_cnt), 72'(0));
        repeat (4) step("stall_after");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter: DEPTH, default 8, queue entries; SHALL be a multiple of 4 and >= 8.
REQ-002 Port: i_fire  in  1  clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  in  1  reset; asynchronous, active-low.
REQ-004 Port: i_redirect  in  1  flush queue and restart fetch at i_redirect_pc.
REQ-005 Port: i_redirect_pc  in  8  new fetch address.
REQ-006 Port: i_write_busy  in  1  SRAM write in progress; SHALL block read issue.
REQ-007 Port: o_read_en  out  1  read request to the four-way SRAM.
REQ-008 Port: o_read_addr  out  32  four packed 8-bit addresses; lane k = bits [8k+7:8k].
REQ-009 Port: i_datas  in  288  four packed 72-bit words, lane k = bits [72k+71:72k], valid one cycle after the matching o_read_en.
REQ-010 Port: o_inst_valid  out  1  queue head valid.
REQ-011 Port: o_inst  out  72  queue head instruction word.
REQ-012 Port: o_inst_pc  out  8  address of o_inst.
REQ-013 Port: i_inst_ready  in  1  consumer accepts head.

Function
REQ-014 Fetch pointer fetch_pc (8 bit); o_read_addr lane k SHALL always equal (fetch_pc + k) mod 256, whether or not o_read_en is high.
REQ-015 o_read_en SHALL be combinational: high iff !i_redirect && !i_write_busy && (count + 4*inflight) <= DEPTH-4.
REQ-016 On a cycle with o_read_en high: fetch_pc <= fetch_pc + 4 mod 256; inflight <= 1; issue_pc <= fetch_pc.
REQ-017 On a cycle with inflight high and no i_redirect: lanes 0..3 of i_datas SHALL be written to the tail in lane order with pc issue_pc+k; count += 4; inflight <= 0 unless a new read issues in the same cycle.
REQ-018 SRAM latency is exactly 1 cycle; at most one read is in flight, and issue and capture may occur in the same cycle.
REQ-019 Pop: when o_inst_valid && i_inst_ready, the head SHALL advance one entry; count -= 1.
REQ-020 Simultaneous capture and pop: count_next = count - 1 + 4.
REQ-021 o_inst_valid = (count != 0); o_inst and o_inst_pc SHALL come from the head registers with no combinational path from i_datas.
REQ-022 Head/tail pointers wrap modulo DEPTH; capture never overflows, which the issue rule in REQ-015 guarantees.
REQ-023 i_redirect SHALL take priority over everything in that cycle: count <= 0, pointers <= 0, inflight <= 0 (data returning that cycle is dropped), fetch_pc <= i_redirect_pc, no pop takes effect, no issue.
REQ-024 The first issue after a redirect occurs in the following cycle at i_redirect_pc, subject to REQ-015.
REQ-025 Address wrap: fetch_pc=254 SHALL issue lanes 254,255,0,1 and then fetch_pc=2.

Reset
REQ-026 While rst is low: fetch_pc=0, count=0, pointers=0, inflight=0, o_inst_valid=0, o_read_en=0, o_read_addr={3,2,1,0}.
REQ-027 Reset asserted mid-operation SHALL discard queue contents and any in-flight read immediately (asynchronously).
REQ-028 Queue data storage need not be reset; the valid flag depends only on count.

Configuration
REQ-029 Macro FETCH_QUEUE_PERF_CNT_EN defined: add output o_stall_cnt (16 bit, reset 0), which increments with saturation at 16'hFFFF on each cycle where !o_read_en && !i_redirect, and clears on i_redirect.
REQ-030 Macro undefined: port o_stall_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset release, ready=1, write_busy=0 -> cycle 0 o_read_en=1, addr {3,2,1,0}; cycle 1 capture; cycle 2 o_inst_valid=1 with o_inst_pc=0, then pcs 1,2,3,4... consecutive with no gaps.
REQ-032 i_inst_ready=0 held, DEPTH=8 -> exactly two issues, count reaches 8, o_read_en stays 0; raise ready -> a new issue occurs once count <= 4.
REQ-033 Redirect to 0xFE in the cycle data returns -> returned words dropped; next cycle addr {0x01,0x00,0xFF,0xFE}; output pcs FE,FF,00,01.
REQ-034 i_write_busy=1 for 3 cycles with an empty queue -> o_read_en=0 for those cycles, fetch_pc unchanged; issue in the cycle after release.
REQ-035 Capture and pop in the same cycle with count=3 -> count=6; rst pulsed low mid-fetch -> o_inst_valid=0 at once, and fetch restarts at pc 0.
REQ-036 With FETCH_QUEUE_PERF_CNT_EN defined and ready=0 for 20 cycles after the queue fills -> o_stall_cnt counts blocked cycles; i_redirect clears it to 0.
